// File: rtl/ppu_requant.sv
// rtl/ppu_requant.sv - bias/scale/round/ReLU/INT4 requantizer with output RAM and per-frame lane sums
module ppu_requant #(
  parameter int LANES = 16,
  parameter int ACC_W = 24,
  parameter int OUT_W = 4,
  parameter int SF_W  = 40,
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ppu_start,
  input  logic [LANES*ACC_W-1:0]   i_acc_data,
  input  logic                     i_relu_en,
  input  logic                     i_cfg_we,
  input  logic                     i_cfg_sel,
  input  logic [3:0]               i_cfg_idx,
  input  logic [LANES*16-1:0]      i_cfg_data,
  output logic                     o_ram_we,
  output logic [LANES*OUT_W-1:0]   o_ram_data,
  output logic [$clog2(DEPTH)-1:0] o_ram_addr,
  output logic                     o_sf_valid,
  output logic [LANES*SF_W-1:0]    o_sf_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [LANES*OUT_W-1:0]   o_rd_data
);
  localparam int CFG_W = 16;
  localparam int BEATS = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = ACC_W + CFG_W + 2;
  localparam logic signed [PW-1:0] RND    = PW'(512);
  localparam logic signed [PW-1:0] SAT_HI = PW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PW-1:0] SAT_LO = -PW'(2 ** (OUT_W - 1));

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nx;
  logic [3:0]             beat, beat_nx;
  logic [AW-5:0]          tile, tile_nx;
  logic [LANES*CFG_W-1:0] scale_tab [BEATS];
  logic [LANES*CFG_W-1:0] bias_tab  [BEATS];
  logic [LANES*OUT_W-1:0] mem [DEPTH];
  logic signed [SF_W-1:0] sf [LANES];
  logic [LANES*OUT_W-1:0] q_nx, q1;
  logic [AW-1:0]          addr1;
  logic                   we1, sf_fire;
  logic                   in_beat, frame_end;

  function automatic logic [OUT_W-1:0] requant(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [CFG_W-1:0] bias,
    input logic signed [CFG_W-1:0] scale,
    input logic                    relu
  );
    logic signed [ACC_W:0]  s;
    logic signed [PW-1:0]   p;
    logic signed [PW-1:0]   r;
    s = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - CFG_W){bias[CFG_W-1]}}, bias};
    p = PW'(s) * PW'(scale);
    r = (p + RND) >>> 10;
    if (relu && r[PW-1]) r = '0;
    if (r > SAT_HI) r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    return r[OUT_W-1:0];
  endfunction

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    tile_nx  = tile;
    case (state)
      IDLE: begin
        if (i_ppu_start) begin
          state_nx = RUN;
          beat_nx  = '0;
        end
      end
      RUN: begin
        beat_nx = beat + 4'd1;
        if (beat == 4'(BEATS - 1)) begin
          state_nx = IDLE;
          tile_nx  = tile + (AW - 4)'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_beat   = (state == RUN);
  assign frame_end = in_beat && (beat == 4'(BEATS - 1)) && (&tile);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      beat  <= '0;
      tile  <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      tile  <= tile_nx;
    end
  end

  // Table rows are read as registered state, so a same-cycle write is seen one beat later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < BEATS; r++) begin
        scale_tab[r] <= {LANES{CFG_W'(1024)}};
        bias_tab[r]  <= '0;
      end
    end else if (i_cfg_we) begin
      if (i_cfg_sel) bias_tab[i_cfg_idx]  <= i_cfg_data;
      else           scale_tab[i_cfg_idx] <= i_cfg_data;
    end
  end

  always_comb begin
    q_nx = '0;
    for (int i = 0; i < LANES; i++) begin
      q_nx[i*OUT_W +: OUT_W] = requant(i_acc_data[i*ACC_W +: ACC_W],
                                       bias_tab[beat][i*CFG_W +: CFG_W],
                                       scale_tab[beat][i*CFG_W +: CFG_W],
                                       i_relu_en);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we1        <= 1'b0;
      addr1      <= '0;
      q1         <= '0;
      sf_fire    <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_data <= '0;
    end else begin
      we1      <= in_beat;
      sf_fire  <= frame_end;
      o_ram_we <= we1;
      if (in_beat) begin
        addr1 <= {tile, beat};
        q1    <= q_nx;
      end
      if (we1) begin
        o_ram_addr <= addr1;
        o_ram_data <= q1;
      end
    end
  end

  // The cycle after a frame's last beat never carries a beat, so snapshot and clear share it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LANES; i++) sf[i] <= '0;
      o_sf_valid <= 1'b0;
      o_sf_data  <= '0;
    end else begin
      o_sf_valid <= sf_fire;
      if (sf_fire) begin
        for (int i = 0; i < LANES; i++) begin
          o_sf_data[i*SF_W +: SF_W] <= sf[i];
          sf[i] <= '0;
        end
      end else if (in_beat) begin
        for (int i = 0; i < LANES; i++) begin
          sf[i] <= sf[i] + SF_W'($signed(i_acc_data[i*ACC_W +: ACC_W]));
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      o_rd_data <= '0;
    end else begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
      o_rd_data <= mem[i_rd_addr];
    end
  end
endmodule

// File: tb/tb_ppu_requant.sv
// tb/tb_ppu_requant.sv - randomized scoreboard bench for ppu_requant against an arithmetic reference model
module tb_ppu_requant;
  logic         clk = 1'b0;
  logic         rst, start, relu, cfg_we, cfg_sel;
  logic [3:0]   cfg_idx;
  logic [255:0] cfg_data;
  logic [383:0] acc_data;
  logic [5:0]   rd_addr;
  logic         ram_we;
  logic [63:0]  ram_data;
  logic [5:0]   ram_addr;
  logic         sf_valid;
  logic [639:0] sf_data;
  logic [63:0]  rd_data;

  always #5 clk = ~clk;

  ppu_requant dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ppu_start(start),
    .i_acc_data (acc_data),
    .i_relu_en  (relu),
    .i_cfg_we   (cfg_we),
    .i_cfg_sel  (cfg_sel),
    .i_cfg_idx  (cfg_idx),
    .i_cfg_data (cfg_data),
    .o_ram_we   (ram_we),
    .o_ram_data (ram_data),
    .o_ram_addr (ram_addr),
    .o_sf_valid (sf_valid),
    .o_sf_data  (sf_data),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data)
  );

  typedef struct packed {int addr; logic [63:0] data; int cyc;} wr_t;
  typedef struct packed {logic [639:0] data; int cyc;} sf_t;

  int  total = 0, bad = 0, cyc = 0;
  bit  mon_on = 0;
  wr_t wq[$];
  sf_t sq[$];

  longint      m_scale [16][16];
  longint      m_bias  [16][16];
  longint      m_acc   [16][16];
  bit          m_relu  [16];
  longint      m_cw    [16];
  longint      m_sf    [16];
  logic [63:0] m_mem   [64];
  int          m_tile;

  logic [63:0] mon_mem [64];
  logic [63:0] rd_exp = '0;
  logic [63:0] wr_data;
  int          wr_addr;
  bit          wr_pend = 0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic longint rnd(input longint lo, input longint hi);
    return longint'($urandom_range(0, int'(hi - lo))) + lo;
  endfunction

  function automatic logic [63:0] rep4(input int v);
    logic [63:0] w;
    for (int i = 0; i < 16; i++) w[i*4 +: 4] = v[3:0];
    return w;
  endfunction

  // Reference: exact rational scaling, round half up via floor division, clamp.
  function automatic logic [3:0] ref_lane(input longint acc, input longint bias,
                                          input longint scale, input bit rl);
    longint num, r;
    num = (acc + bias) * scale + 512;
    r = num / 1024;
    if ((num % 1024) != 0 && num < 0) r = r - 1;
    if (rl && r < 0) r = 0;
    if (r > 7) r = 7;
    if (r < -8) r = -8;
    return r[3:0];
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) begin
        m_scale[r][i] = 1024;
        m_bias[r][i]  = 0;
      end
    for (int a = 0; a < 64; a++) m_mem[a] = '0;
    for (int i = 0; i < 16; i++) m_sf[i] = 0;
    m_tile = 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int a = 0; a < 64; a++) mon_mem[a] = '0;
      rd_exp  = '0;
      wr_pend = 0;
    end else begin
      rd_exp = mon_mem[rd_addr];
      if (wr_pend) mon_mem[wr_addr] = wr_data;
      wr_pend = 0;
    end
  end

  initial begin
    wr_t e;
    sf_t s;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (ram_we) begin
          if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL ram_we_unexpected: got write to %0d want none", ram_addr);
          end else begin
            e = wq.pop_front();
            chk("ram_addr", ram_addr, e.addr);
            chk("ram_data", ram_data, e.data);
            chk("ram_cycle", cyc, e.cyc);
            wr_pend = 1; wr_addr = e.addr; wr_data = e.data;
          end
        end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
          total++; bad++;
          $display("FAIL ram_we_missing: got none want write to %0d at cycle %0d", wq[0].addr, wq[0].cyc);
          void'(wq.pop_front());
        end
        if (sf_valid) begin
          if (sq.size() == 0) begin
            total++; bad++;
            $display("FAIL sf_unexpected: got pulse at cycle %0d want none", cyc);
          end else begin
            s = sq.pop_front();
            chk("sf_data", sf_data, s.data);
            chk("sf_cycle", cyc, s.cyc);
          end
        end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
          total++; bad++;
          $display("FAIL sf_missing: got none want pulse at cycle %0d", sq[0].cyc);
          void'(sq.pop_front());
        end
        chk("rd_data", rd_data, rd_exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 0; cfg_we = 0; relu = 0;
    end
  endtask

  task automatic cfg_write(input bit sel, input int row);
    @(negedge clk);
    start = 0; cfg_we = 1; cfg_sel = sel; cfg_idx = row[3:0];
    for (int i = 0; i < 16; i++) begin
      cfg_data[i*16 +: 16] = m_cw[i][15:0];
      if (sel) m_bias[row][i] = m_cw[i];
      else     m_scale[row][i] = m_cw[i];
    end
  endtask

  task automatic run_tile(input int start_beat, input int cw_beat, input bit cw_sel, input int cw_row);
    wr_t e;
    sf_t s;
    logic [63:0] w;
    @(negedge clk);
    start = 1; cfg_we = 0; relu = 0;
    acc_data = {12{$urandom()}};
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      start = (b == start_beat);
      relu  = m_relu[b];
      for (int i = 0; i < 16; i++) acc_data[i*24 +: 24] = m_acc[b][i][23:0];
      cfg_we  = (b == cw_beat);
      cfg_sel = cw_sel;
      cfg_idx = cw_row[3:0];
      for (int i = 0; i < 16; i++) cfg_data[i*16 +: 16] = m_cw[i][15:0];
      for (int i = 0; i < 16; i++) w[i*4 +: 4] = ref_lane(m_acc[b][i], m_bias[b][i], m_scale[b][i], m_relu[b]);
      e.addr = m_tile * 16 + b; e.data = w; e.cyc = cyc + 2;
      wq.push_back(e);
      m_mem[e.addr] = w;
      for (int i = 0; i < 16; i++) m_sf[i] += m_acc[b][i];
      if (b == cw_beat)
        for (int i = 0; i < 16; i++)
          if (cw_sel) m_bias[cw_row][i] = m_cw[i];
          else        m_scale[cw_row][i] = m_cw[i];
      if (b == 15 && m_tile == 3) begin
        for (int i = 0; i < 16; i++) begin
          s.data[i*40 +: 40] = m_sf[i][39:0];
          m_sf[i] = 0;
        end
        s.cyc = cyc + 2;
        sq.push_back(s);
      end
    end
    m_tile = (m_tile + 1) % 4;
  endtask

  task automatic rd_chk(input string name, input int addr, input logic [63:0] exp);
    @(negedge clk);
    start = 0; cfg_we = 0; relu = 0; rd_addr = addr[5:0];
    @(negedge clk);
    chk(name, rd_data, exp);
  endtask

  task automatic fill_tile(input longint lo, input longint hi, input bit rand_relu);
    for (int b = 0; b < 16; b++) begin
      m_relu[b] = rand_relu ? bit'($urandom_range(0, 1)) : 1'b0;
      for (int i = 0; i < 16; i++) m_acc[b][i] = rnd(lo, hi);
    end
  endtask

  longint      pat_in  [5] = '{100, -100, 5, -5, 0};
  logic [3:0]  pat_out [5] = '{4'h7, 4'h8, 4'h5, 4'hB, 4'h0};
  logic [63:0] w16;

  initial begin
    rst = 1; start = 0; relu = 0; cfg_we = 0; cfg_sel = 0; cfg_idx = '0;
    cfg_data = '0; acc_data = '0; rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_sf_valid", sf_valid, 0);
    chk("rst_sf_data", sf_data, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 0;
    mon_on = 1;

    // tile 0 with default tables
    for (int b = 0; b < 16; b++) begin
      m_relu[b] = 0;
      for (int i = 0; i < 16; i++) m_acc[b][i] = 3;
    end
    run_tile(-1, -1, 0, 0);

    // tile 1: rounding, saturation, ReLU and bias corner beats
    for (int i = 0; i < 16; i++) m_cw[i] = 1;
    cfg_write(1, 2);
    for (int i = 0; i < 16; i++) m_cw[i] = 512;
    cfg_write(0, 4);
    cfg_write(0, 5);
    fill_tile(-40, 40, 0);
    for (int i = 0; i < 16; i++) begin
      m_acc[0][i] = pat_in[i % 5];
      m_acc[1][i] = -5;
      m_acc[2][i] = 6;
      m_acc[3][i] = 6;
      m_acc[4][i] = 3;
      m_acc[5][i] = -3;
    end
    m_relu[1] = 1;
    for (int b = 0; b < 6; b++) if (b != 1) m_relu[b] = 0;
    run_tile(-1, -1, 0, 0);
    idle(4);
    rd_chk("mem0_acc3", 0, 64'h3333333333333333);
    rd_chk("mem15_acc3", 15, 64'h3333333333333333);
    for (int i = 0; i < 16; i++) w16[i*4 +: 4] = pat_out[i % 5];
    rd_chk("mem16_sat", 16, w16);
    rd_chk("mem17_relu", 17, 64'h0);
    rd_chk("mem18_bias", 18, 64'h7777777777777777);
    rd_chk("mem19_nobias", 19, 64'h6666666666666666);
    rd_chk("mem20_round_up", 20, 64'h2222222222222222);
    rd_chk("mem21_round_neg", 21, 64'hFFFFFFFFFFFFFFFF);

    // random tables, then tiles 2 and 3 with mid-tile cfg writes and a stray start
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 16; i++) m_cw[i] = rnd(-2048, 2047);
      cfg_write(0, r);
      for (int i = 0; i < 16; i++) m_cw[i] = rnd(-20, 20);
      cfg_write(1, r);
    end
    fill_tile(-40, 40, 1);
    for (int i = 0; i < 16; i++) m_cw[i] = rnd(-2048, 2047);
    run_tile(7, 5, 0, 5);
    fill_tile(-40, 40, 1);
    for (int i = 0; i < 16; i++) m_cw[i] = rnd(-20, 20);
    run_tile(-1, 10, 1, 12);

    // defaults again, then the k = 0..63 frame
    for (int i = 0; i < 16; i++) m_cw[i] = 1024;
    for (int r = 0; r < 16; r++) cfg_write(0, r);
    for (int i = 0; i < 16; i++) m_cw[i] = 0;
    for (int r = 0; r < 16; r++) cfg_write(1, r);
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 16; b++) begin
        m_relu[b] = 0;
        for (int i = 0; i < 16; i++) m_acc[b][i] = t * 16 + b;
      end
      run_tile(-1, -1, 0, 0);
    end
    idle(4);
    foreach (pat_in[j]) begin
      int k;
      k = j * 13 + 2;
      rd_chk("mem_k", k, rep4(k < 7 ? k : 7));
    end
    rd_chk("mem63_k", 63, rep4(7));

    // next frame restarts at address 0 with cleared sums; includes full-range lanes
    fill_tile(-8388608, 8388607, 1);
    run_tile(-1, -1, 0, 0);
    for (int t = 0; t < 3; t++) begin
      fill_tile(-300, 300, 1);
      run_tile(-1, -1, 0, 0);
    end
    idle(4);
    rd_chk("mem0_tile4", 0, m_mem[0]);

    // reset during beat 8
    fill_tile(-40, 40, 0);
    @(negedge clk);
    start = 1; cfg_we = 0; relu = 0;
    for (int b = 0; b < 8; b++) begin
      wr_t e;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 16; i++) acc_data[i*24 +: 24] = m_acc[b][i][23:0];
      if (b <= 6) begin
        for (int i = 0; i < 16; i++) e.data[i*4 +: 4] = ref_lane(m_acc[b][i], m_bias[b][i], m_scale[b][i], 0);
        e.addr = m_tile * 16 + b; e.cyc = cyc + 2;
        wq.push_back(e);
      end
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    idle(3);
    for (int a = 0; a < 16; a += 5) rd_chk("mem_after_abort", a, 64'h0);
    for (int b = 0; b < 16; b++) begin
      m_relu[b] = 0;
      for (int i = 0; i < 16; i++) m_acc[b][i] = 2;
    end
    run_tile(-1, -1, 0, 0);
    idle(4);
    rd_chk("mem0_after_abort", 0, 64'h2222222222222222);
    rd_chk("mem16_after_abort", 16, 64'h0);

    idle(10);
    chk("wr_queue_drained", wq.size(), 0);
    chk("sf_queue_drained", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish within 20000 cycles");
    $fatal(1, "timeout");
  end
endmodule
